// File: rtl/uart_recv.sv
// UART receiver: 8N1 by default; defining UART_RX_PARITY_EN switches it to 8E1 and adds parity_err.
// Each byte is presented on uart_data with a one-cycle uart_done strobe.
module uart_recv #(
  parameter int CLK_FREQ = 50000000,
  parameter int UART_BPS = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rxd,
  output logic [7:0] uart_data,
  output logic       uart_done,
  output logic       frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam int          BPS_CNT = CLK_FREQ / UART_BPS;
  localparam logic [15:0] CNT_MAX = 16'(BPS_CNT - 1);
  localparam logic [15:0] CNT_MID = 16'(BPS_CNT / 2);
`ifdef UART_RX_PARITY_EN
  localparam logic [3:0]  STOP_IDX = 4'd10;
`else
  localparam logic [3:0]  STOP_IDX = 4'd9;
`endif

  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

  state_t      state, state_nxt;
  logic        rx_s1, rx_s2, rx_s3;
  logic        start_flag;
  logic        mid;
  logic [15:0] clk_cnt;
  logic [3:0]  bit_cnt;
  logic [2:0]  buf_idx;
  logic [7:0]  rx_buf;
  logic        stop_bit;
  logic        par_bad;

  // Two flops for metastability, a third only to see the falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= uart_rxd;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  assign start_flag = (state == IDLE) & rx_s3 & ~rx_s2;
  assign mid        = (state == RECV) && (clk_cnt == CNT_MID);
  assign buf_idx    = 3'(bit_cnt - 4'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start_flag) state_nxt = RECV;
      RECV: begin
        if (mid) begin
          if (bit_cnt == 4'd0 && rx_s2) state_nxt = IDLE;
          else if (bit_cnt == STOP_IDX) state_nxt = CHECK;
        end
      end
      CHECK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_cnt <= 16'd0;
      bit_cnt <= 4'd0;
    end else if (state == IDLE) begin
      clk_cnt <= 16'd0;
      bit_cnt <= 4'd0;
    end else if (clk_cnt == CNT_MAX) begin
      clk_cnt <= 16'd0;
      bit_cnt <= bit_cnt + 4'd1;
    end else begin
      clk_cnt <= clk_cnt + 16'd1;
    end
  end

  // Shift register holds payload only, so it carries no reset.
  always_ff @(posedge clk) begin
    if (mid && bit_cnt >= 4'd1 && bit_cnt <= 4'd8) rx_buf[buf_idx] <= rx_s2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          stop_bit <= 1'b1;
    else if (mid && bit_cnt == STOP_IDX) stop_bit <= rx_s2;
  end

`ifdef UART_RX_PARITY_EN
  logic par_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       par_bit <= 1'b0;
    else if (mid && bit_cnt == 4'd9)  par_bit <= rx_s2;
  end

  assign par_bad = ^{rx_buf, par_bit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_err <= 1'b0;
    else        parity_err <= (state == CHECK) && par_bad;
  end
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uart_data <= 8'h00;
      uart_done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      uart_done <= 1'b0;
      frame_err <= 1'b0;
      if (state == CHECK) begin
        frame_err <= ~stop_bit;
        if (stop_bit && !par_bad) begin
          uart_done <= 1'b1;
          uart_data <= rx_buf;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_recv.sv
// Scoreboard bench for uart_recv; honours UART_RX_PARITY_EN when defined.
module tb_uart_recv;

  localparam int CLK_FREQ = 50000000;
  localparam int UART_BPS = 500000;
  localparam int BPS      = CLK_FREQ / UART_BPS;
`ifdef UART_RX_PARITY_EN
  localparam int STOP_IDX = 10;
`else
  localparam int STOP_IDX = 9;
`endif
  localparam int LAT_LO = STOP_IDX * BPS + BPS / 2;
  localparam int LAT_HI = LAT_LO + 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       uart_rxd;
  logic [7:0] uart_data;
  logic       uart_done;
  logic       frame_err;
  logic       perr;

`ifdef UART_RX_PARITY_EN
  uart_recv #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rxd(uart_rxd), .uart_data(uart_data),
    .uart_done(uart_done), .frame_err(frame_err), .parity_err(perr));
`else
  uart_recv #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rxd(uart_rxd), .uart_data(uart_data),
    .uart_done(uart_done), .frame_err(frame_err));
  assign perr = 1'b0;
`endif

  always #5 clk = ~clk;

  // kind bits: 1 = uart_done, 2 = frame_err, 4 = parity_err
  typedef struct {
    int       kind;
    logic [7:0] data;
    longint   t0;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad = 0;
  logic [7:0] model_data = 8'h00;
  logic       prev_done = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int   obs;
    exp_t e;
    if (!rst_n) begin
      model_data = 8'h00;
      prev_done  = 1'b0;
    end else begin
      obs = (uart_done ? 1 : 0) + (frame_err ? 2 : 0) + (perr ? 4 : 0);
      if (uart_done) chk("done_width", int'(prev_done), 0);
      if (obs != 0) begin
        if (sb.size() == 0) begin
          chk("unexpected", obs, 0);
        end else begin
          e = sb.pop_front();
          chk("kind", obs, e.kind);
          chk("latency_ok", int'((($time - e.t0) / 10) >= LAT_LO && (($time - e.t0) / 10) <= LAT_HI), 1);
          if (uart_done) begin
            chk("data", int'(uart_data), int'(e.data));
            model_data = e.data;
          end
        end
      end else if (uart_data !== model_data) begin
        chk("data_hold", int'(uart_data), int'(model_data));
      end
      prev_done = uart_done;
    end
  end

  task automatic wait_bit();
    repeat (BPS) @(negedge clk);
  endtask

  task automatic idle(input int bits);
    uart_rxd = 1'b1;
    repeat (bits * BPS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic pflip);
    exp_t e;
    logic pf;
`ifdef UART_RX_PARITY_EN
    pf = pflip;
`else
    pf = 1'b0;
`endif
    e.data = d;
    e.kind = ((stop_v && !pf) ? 1 : 0) + (stop_v ? 0 : 2) + (pf ? 4 : 0);
    e.t0   = $time;
    sb.push_back(e);
    uart_rxd = 1'b0;
    wait_bit();
    for (int i = 0; i < 8; i++) begin
      uart_rxd = d[i];
      wait_bit();
    end
`ifdef UART_RX_PARITY_EN
    uart_rxd = (^d) ^ pf;
    wait_bit();
`endif
    uart_rxd = stop_v;
    wait_bit();
  endtask

  initial begin
    logic [7:0] f;
    rst_n    = 1'b0;
    uart_rxd = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_data", int'(uart_data), 0);
    chk("rst_done", int'(uart_done), 0);
    chk("rst_ferr", int'(frame_err), 0);
    chk("rst_perr", int'(perr), 0);
    rst_n = 1'b1;
    idle(2);

    send_frame(8'h55, 1'b1, 1'b0);
    idle(2);
    chk("after_55", int'(uart_data), 8'h55);

    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle(2);
    chk("after_b2b", int'(uart_data), 8'hFF);

    uart_rxd = 1'b0;
    repeat (BPS / 5) @(negedge clk);
    idle(2);
    chk("glitch_sb", sb.size(), 0);
    send_frame(8'hA3, 1'b1, 1'b0);
    idle(2);
    chk("after_a3", int'(uart_data), 8'hA3);

    send_frame(8'h3C, 1'b0, 1'b0);
    uart_rxd = 1'b0;
    repeat (3 * BPS) @(negedge clk);
    idle(2);
    chk("ferr_keep", int'(uart_data), 8'hA3);

    // Interrupted frame 0xF5: bits 4..7 and stop are high, so no edge follows reset
    f = 8'hF5;
    uart_rxd = 1'b0;
    wait_bit();
    for (int i = 0; i < 4; i++) begin
      uart_rxd = f[i];
      wait_bit();
    end
    uart_rxd = f[4];
    repeat (BPS / 5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_data", int'(uart_data), 0);
    chk("mid_rst_done", int'(uart_done), 0);
    chk("mid_rst_ferr", int'(frame_err), 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (BPS - BPS / 5 - 5) @(negedge clk);
    for (int i = 5; i < 8; i++) begin
      uart_rxd = f[i];
      wait_bit();
    end
`ifdef UART_RX_PARITY_EN
    uart_rxd = ^f;
    wait_bit();
`endif
    uart_rxd = 1'b1;
    wait_bit();
    idle(2);
    chk("rst_frame_quiet", int'(uart_data), 0);

    send_frame(8'h81, 1'b1, 1'b0);
    idle(2);
    chk("after_81", int'(uart_data), 8'h81);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    idle(2);
    chk("after_07", int'(uart_data), 8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    idle(2);
    send_frame(8'h5A, 1'b0, 1'b1);
    idle(2);
    chk("perr_keep", int'(uart_data), 8'h07);
`endif

    for (int i = 0; i < 40 * BPS && sb.size() != 0; i++) @(negedge clk);
    chk("drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
